// File: rtl/updown_pkg.sv
// Shared types and constants for the up/down counter sequencing controller.
package updown_pkg;

  localparam int unsigned WIDTH_DEF = 4;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_STEP  = 2'd1,
    ST_DWELL = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  // Dwell counter width; at least one bit so DWELL=0 still elaborates.
  function automatic int unsigned dwell_w(input int unsigned d);
    return (d < 1) ? 1 : $clog2(d + 1);
  endfunction

endpackage

// File: rtl/updown_seq_ctrl_if.sv
// Command and status bundle between a requester and the sequencing controller.
interface updown_seq_ctrl_if
  import updown_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF
);

  logic             cmd_valid;
  logic             cmd_ready;
  logic [WIDTH-1:0] cmd_target;
  logic             abort;
  logic [WIDTH-1:0] count;
  logic             dir;
  logic             busy;
  logic             done;

  modport master (
    output cmd_valid, cmd_target, abort,
    input  cmd_ready, count, dir, busy, done
  );

  modport slave (
    input  cmd_valid, cmd_target, abort,
    output cmd_ready, count, dir, busy, done
  );

endinterface

// File: rtl/updown_counter_core.sv
// Plain enabled up/down count register; async active-high reset to zero.
module updown_counter_core #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] r_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (en) begin
      r_count <= up ? r_count + WIDTH'(1) : r_count - WIDTH'(1);
    end
  end

  assign count = r_count;

endmodule

// File: rtl/updown_seq_ctrl.sv
// Steps the counter toward an accepted target, dwells there, then pulses done.
module updown_seq_ctrl
  import updown_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF,
  parameter int unsigned DWELL = 3
) (
  input  logic               clk,
  input  logic               rst,
  updown_seq_ctrl_if.slave   bus
);

  localparam int unsigned   DW       = dwell_w(DWELL);
  localparam logic [DW-1:0] DWELL_LD = DW'(DWELL);
  // State entered once the count sits on the target.
  localparam state_e        ST_ARRIVE = (DWELL == 0) ? ST_DONE : ST_DWELL;

  state_e           r_state;
  logic [WIDTH-1:0] r_target;
  logic [DW-1:0]    r_dwell;
  logic             r_dir;

  logic [WIDTH-1:0] w_count;
  logic [WIDTH-1:0] w_count_nxt;
  logic             w_en;

  // Abort freezes the count on the edge it is sampled.
  assign w_en        = (r_state == ST_STEP) && !bus.abort;
  assign w_count_nxt = r_dir ? w_count + WIDTH'(1) : w_count - WIDTH'(1);

  updown_counter_core #(.WIDTH(WIDTH)) u_core (
    .clk   (clk),
    .rst   (rst),
    .en    (w_en),
    .up    (r_dir),
    .count (w_count)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_target <= '0;
      r_dwell  <= '0;
      r_dir    <= DIR_UP;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (bus.cmd_valid) begin
            r_target <= bus.cmd_target;
            if (bus.cmd_target > w_count) begin
              r_dir   <= DIR_UP;
              r_state <= ST_STEP;
            end else if (bus.cmd_target < w_count) begin
              r_dir   <= DIR_DOWN;
              r_state <= ST_STEP;
            end else begin
              r_dwell <= DWELL_LD;
              r_state <= ST_ARRIVE;
            end
          end
        end
        ST_STEP: begin
          if (bus.abort) begin
            r_state <= ST_IDLE;
          end else if (w_count_nxt == r_target) begin
            r_dwell <= DWELL_LD;
            r_state <= ST_ARRIVE;
          end
        end
        ST_DWELL: begin
          r_dwell <= r_dwell - DW'(1);
          if (bus.abort) begin
            r_state <= ST_IDLE;
          end else if (r_dwell == DW'(1)) begin
            r_state <= ST_DONE;
          end
        end
        ST_DONE: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.cmd_ready = (r_state == ST_IDLE);
  assign bus.busy      = (r_state != ST_IDLE);
  assign bus.done      = (r_state == ST_DONE);
  assign bus.count     = w_count;
  assign bus.dir       = r_dir;

endmodule

// File: tb/tb_updown_seq_ctrl.sv
// Bench for updown_seq_ctrl: two instances (DWELL=3 and DWELL=0) checked each cycle
// against a timeline model of each command, plus directed literal checks.
module tb_updown_seq_ctrl;

  localparam int unsigned W  = 4;
  localparam int unsigned D0 = 3;
  localparam int unsigned D1 = 0;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         s_valid = 1'b0;
  logic         s_abort = 1'b0;
  logic [W-1:0] s_target = '0;

  always #5 clk = ~clk;

  updown_seq_ctrl_if #(.WIDTH(W)) if0 ();
  updown_seq_ctrl_if #(.WIDTH(W)) if1 ();

  assign if0.cmd_valid  = s_valid;
  assign if0.cmd_target = s_target;
  assign if0.abort      = s_abort;
  assign if1.cmd_valid  = s_valid;
  assign if1.cmd_target = s_target;
  assign if1.abort      = s_abort;

  updown_seq_ctrl #(.WIDTH(W), .DWELL(D0)) dut0 (.clk(clk), .rst(rst), .bus(if0));
  updown_seq_ctrl #(.WIDTH(W), .DWELL(D1)) dut1 (.clk(clk), .rst(rst), .bus(if1));

  int checks = 0;
  int errors = 0;

  // Model: a command is a timeline; k edges after acceptance the count has moved
  // min(k,n) toward the target, done shows at k==n+dwell, idle the edge after.
  int m_dw    [2];
  bit m_active[2];
  int m_k     [2];
  int m_c0    [2];
  int m_tg    [2];
  int m_n     [2];
  int m_count [2];
  bit m_dir   [2];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_dw[0] = int'(D0);
    m_dw[1] = int'(D1);
    for (int i = 0; i < 2; i++) begin
      m_active[i] = 1'b0;
      m_k[i]      = 0;
      m_c0[i]     = 0;
      m_tg[i]     = 0;
      m_n[i]      = 0;
      m_count[i]  = 0;
      m_dir[i]    = 1'b1;
    end
  endfunction

  function automatic void model_edge(input bit v, input int t, input bit a);
    int mv;
    for (int i = 0; i < 2; i++) begin
      if (!m_active[i]) begin
        if (v) begin
          m_active[i] = 1'b1;
          m_k[i]      = 0;
          m_c0[i]     = m_count[i];
          m_tg[i]     = t;
          m_n[i]      = (t > m_count[i]) ? t - m_count[i] : m_count[i] - t;
          if (t > m_count[i]) m_dir[i] = 1'b1;
          else if (t < m_count[i]) m_dir[i] = 1'b0;
        end
      end else if (m_k[i] == m_n[i] + m_dw[i]) begin
        m_active[i] = 1'b0;
      end else if (a) begin
        m_active[i] = 1'b0;
      end else begin
        m_k[i]++;
        mv = (m_k[i] < m_n[i]) ? m_k[i] : m_n[i];
        m_count[i] = (m_tg[i] > m_c0[i]) ? m_c0[i] + mv : m_c0[i] - mv;
      end
    end
  endfunction

  task automatic compare();
    chk("u0 count", int'(if0.count),     m_count[0]);
    chk("u0 dir",   int'(if0.dir),       int'(m_dir[0]));
    chk("u0 busy",  int'(if0.busy),      int'(m_active[0]));
    chk("u0 ready", int'(if0.cmd_ready), int'(!m_active[0]));
    chk("u0 done",  int'(if0.done),      int'(m_active[0] && (m_k[0] == m_n[0] + m_dw[0])));
    chk("u1 count", int'(if1.count),     m_count[1]);
    chk("u1 dir",   int'(if1.dir),       int'(m_dir[1]));
    chk("u1 busy",  int'(if1.busy),      int'(m_active[1]));
    chk("u1 ready", int'(if1.cmd_ready), int'(!m_active[1]));
    chk("u1 done",  int'(if1.done),      int'(m_active[1] && (m_k[1] == m_n[1] + m_dw[1])));
  endtask

  task automatic step(input bit v, input int t, input bit a);
    s_valid  = v;
    s_target = W'(t);
    s_abort  = a;
    @(posedge clk);
    model_edge(v, t, a);
    @(negedge clk);
    compare();
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && m_active[0]; i++) step(1'b0, 0, 1'b0);
    if (m_active[0]) begin
      checks++;
      errors++;
      $display("FAIL drain timeout: unit 0 still busy at %0t", $time);
    end
  endtask

  task automatic run_to(input int t);
    step(1'b1, t, 1'b0);
    drain();
  endtask

  initial begin
    model_reset();
    @(negedge clk);
    chk("reset count", int'(if0.count), 0);
    chk("reset dir",   int'(if0.dir),   1);
    chk("reset busy",  int'(if0.busy),  0);
    chk("reset done",  int'(if0.done),  0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("ready after reset", int'(if0.cmd_ready), 1);
    compare();

    // Equal target: DWELL=0 finishes at once, DWELL=3 dwells three clocks
    step(1'b1, 0, 1'b0);
    chk("eq d0 done after E0", int'(if1.done), 1);
    chk("eq d3 busy after E0", int'(if0.busy), 1);
    chk("eq d3 no done E0",    int'(if0.done), 0);
    step(1'b0, 0, 1'b0);
    step(1'b0, 0, 1'b0);
    step(1'b0, 0, 1'b0);
    chk("eq d3 done after E3", int'(if0.done), 1);
    step(1'b0, 0, 1'b0);

    // Count up 0 -> 9
    step(1'b1, 9, 1'b0);
    chk("up dir", int'(if0.dir), 1);
    for (int i = 0; i < 9; i++) begin
      step(1'b0, 0, 1'b0);
      chk("up count", int'(if0.count), i + 1);
    end
    step(1'b0, 0, 1'b0);
    step(1'b0, 0, 1'b0);
    chk("up no early done", int'(if0.done), 0);
    step(1'b0, 0, 1'b0);
    chk("up done after E12", int'(if0.done), 1);
    step(1'b0, 0, 1'b0);
    chk("up ready after E13", int'(if0.cmd_ready), 1);

    // Count down 9 -> 2
    step(1'b1, 2, 1'b0);
    chk("down dir", int'(if0.dir), 0);
    for (int i = 0; i < 7; i++) begin
      step(1'b0, 0, 1'b0);
      chk("down count", int'(if0.count), 8 - i);
    end
    step(1'b0, 0, 1'b0);
    step(1'b0, 0, 1'b0);
    step(1'b0, 0, 1'b0);
    chk("down done after E10", int'(if0.done), 1);
    step(1'b0, 0, 1'b0);
    chk("down count holds", int'(if0.count), 2);

    // Equal target at 5
    run_to(5);
    step(1'b1, 5, 1'b0);
    chk("eq5 count", int'(if0.count), 5);
    step(1'b0, 0, 1'b0);
    step(1'b0, 0, 1'b0);
    step(1'b0, 0, 1'b0);
    chk("eq5 done after E3", int'(if0.done), 1);
    step(1'b0, 0, 1'b0);

    // Full range with a blocked command held throughout
    run_to(0);
    step(1'b1, 15, 1'b0);
    for (int i = 0; i < 15; i++) begin
      step(1'b1, 3, 1'b0);
      chk("full busy blocks", int'(if0.cmd_ready), 0);
    end
    chk("full reach 15", int'(if0.count), 15);
    for (int i = 0; i < 10 && m_active[0]; i++) step(1'b1, 3, 1'b0);
    step(1'b1, 3, 1'b0);
    chk("held cmd accepted", int'(if0.busy), 1);
    chk("held cmd dir", int'(if0.dir), 0);
    drain();
    chk("held cmd count", int'(if0.count), 3);
    run_to(15);
    run_to(0);
    chk("full reach 0", int'(if0.count), 0);

    // Abort mid-step
    step(1'b1, 12, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b0, 0, 1'b0);
    chk("abort pre count", int'(if0.count), 4);
    step(1'b0, 0, 1'b1);
    chk("abort busy",  int'(if0.busy),  0);
    chk("abort count", int'(if0.count), 4);
    chk("abort done",  int'(if0.done),  0);
    step(1'b1, 7, 1'b0);
    chk("after abort accept", int'(if0.busy), 1);
    drain();

    // Async reset mid-step
    run_to(0);
    step(1'b1, 10, 1'b0);
    for (int i = 0; i < 6; i++) step(1'b0, 0, 1'b0);
    chk("pre reset count", int'(if0.count), 6);
    #1 rst = 1'b1;
    #1;
    chk("async rst count", int'(if0.count), 0);
    chk("async rst busy",  int'(if0.busy),  0);
    chk("async rst done",  int'(if0.done),  0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    compare();
    run_to(5);
    chk("post reset run", int'(if0.count), 5);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 3) != 0), int'($urandom_range(0, 15)),
           ($urandom_range(0, 19) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete by %0t", $time);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/updown_seq_ctrl.md
Name: updown_seq_ctrl

Overview:
Sequencing controller for the 4-bit up/down counter datapath. It accepts a target value over a valid/ready command interface, picks the count direction, and steps the counter one LSB per clock until it reaches the target. It then holds the count for a programmable dwell time and signals completion with a one-cycle pulse. It is the block that owns the counter's enable and direction lines, so upstream logic issues targets rather than toggling direction by hand.

Parameters:
WIDTH, 4, counter and target width in bits
DWELL, 3, clocks held at target before done; 0 is legal and means no dwell

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous reset, active-high
cmd_valid  input  1  target command present
cmd_ready  output  1  controller can accept a command (high only in IDLE)
cmd_target  input  WIDTH  requested final count value
abort  input  1  cancel the command in flight
count  output  WIDTH  current counter value
dir  output  1  1 = counting up, 0 = counting down
busy  output  1  high in STEP, DWELL and DONE
done  output  1  one-cycle pulse; command completed normally

Behaviour:
- Reset (async, rst=1):
  - state=IDLE, count=0, dir=1, done=0, busy=0, dwell counter=0.
  - cmd_ready=1 once reset is released.
- States: IDLE, STEP, DWELL, DONE. cmd_ready=(state==IDLE); busy=(state!=IDLE); done=(state==DONE). All three are decoded from the registered state.
- IDLE:
  - Accept when cmd_valid&&cmd_ready at edge E0; latch cmd_target.
  - If target>count: dir<=1, go to STEP.
  - If target<count: dir<=0, go to STEP.
  - If target==count: dir unchanged; go to DWELL with dwell counter=DWELL, or straight to DONE when DWELL=0.
- STEP:
  - Each edge, count moves by 1 in the dir direction (unsigned).
  - On the edge where count becomes the target: go to DWELL (load DWELL), or DONE if DWELL=0.
  - With n=|target-count|, count updates at E1..En. The count never wraps, because it always moves toward an in-range target.
- DWELL: count frozen; the dwell counter decrements each edge. On the edge where it equals 1, go to DONE. Exactly DWELL clocks are spent in DWELL.
- DONE: lasts exactly one clock, then IDLE. The done pulse for a moving command lands in the cycle after edge En+DWELL.
- abort:
  - Sampled in STEP or DWELL; it has priority over every transition.
  - Next state is IDLE, count frozen at its current value, no done pulse.
  - Ignored in IDLE and DONE (in DONE the done pulse still completes).
- cmd_valid while busy is ignored and not queued; the requester must hold cmd_valid until it sees cmd_ready.
- Reset during STEP or DWELL: immediate return to reset values; the command is lost.
- dir holds its last value in IDLE, DWELL and DONE.

Decomposition:
- Shared package, updown_pkg:
  - state enumeration (IDLE, STEP, DWELL, DONE)
  - DIR_UP=1 and DIR_DOWN=0
  - default WIDTH constant
- One natural sub-module, updown_counter_core (clk, rst, en, up, count):
  - plain enabled up/down register, async active-high reset to 0
  - driven by the FSM with en=(state==STEP), up=dir
- The FSM, dwell counter and target register live in updown_seq_ctrl.

Test Plan:
1. Count up: reset, then cmd_target=9 accepted at E0 from count=0 -> dir=1; count reads 1..9 at E1..E9; busy high; done pulses for one cycle after E12; cmd_ready returns high after E13.
2. Count down: from count=9, cmd_target=2 -> dir=0; count 8..2 at E1..E7; done pulse after E10; count then stays 2.
3. Equal target: count=5, cmd_target=5 -> no count change; DWELL entered at E0; done pulse after E3. Repeat with DWELL=0 -> done pulse in the cycle after E0.
4. Full range and busy blocking: 0 -> 15 then 15 -> 0 -> counts hit 15 and 0 with no wrap. A cmd_valid with target=3 asserted mid-run is ignored (cmd_ready=0) and accepted only once back in IDLE.
5. Abort: target=12 from 0, abort at the edge after count reaches 4 -> state IDLE; count stays 4; done never asserts; a new command is accepted next cycle.
6. Async reset mid-STEP: rst pulsed between edges while count=6 -> count=0, busy=0, done=0 immediately with no clock edge; normal operation resumes after release.
